apb_i2c_regbank: RTL and testbench
==================================

// Module: apb_i2c_regbank
// PURPOSE
// Parametrised APB3 slave register bank in front of the I2C core and its TX/RX FIFOs.
// Adds the following on top of a plain decode:
//   - programmable wait states and a real SETUP/ACCESS state machine;
//   - PSLVERR on bad accesses (unmapped address, TX full, RX empty);
//   - FIFO status register;
//   - sticky, maskable interrupt sources with write-1-to-clear.
// Sits between the APB interconnect and the I2C core/FIFOs.
// PARAMETERS
// ADDR_W       32  APB address width; decode uses PADDR[7:0], upper bits must be 0 or the access errors
// DATA_W       32  APB/FIFO data width
// CFG_W        14  width of CONFIG register output
// TMO_W        14  width of TIMEOUT register output
// WAIT_STATES  0   extra ACCESS cycles before PREADY (0..15)
// PORTS
// PCLK         in   1       clock, all logic on rising edge
// PRESET       in   1       reset: one clock; reset is synchronous and active-high
// PSEL         in   1       APB select
// PENABLE      in   1       APB access phase
// PWRITE       in   1       1=write, 0=read
// PADDR        in   ADDR_W  byte address
// PWDATA       in   DATA_W  write data
// PRDATA       out  DATA_W  read data, valid only while PREADY=1, else 0
// PREADY       out  1       transfer complete
// PSLVERR      out  1       transfer error, valid only while PREADY=1, else 0
// tx_wr_en     out  1       one-cycle push strobe to TX FIFO
// tx_wdata     out  DATA_W  TX push data (=PWDATA)
// tx_full      in   1       TX FIFO full
// tx_empty     in   1       TX FIFO empty
// rx_rd_en     out  1       one-cycle pop strobe to RX FIFO (show-ahead FIFO)
// rx_rdata     in   DATA_W  RX FIFO head word
// rx_empty     in   1       RX FIFO empty
// rx_full      in   1       RX FIFO full
// i2c_error    in   1       I2C core error level
// cfg          out  CFG_W   CONFIG register
// tmo          out  TMO_W   TIMEOUT register
// irq          out  1       registered interrupt = |(INT_STAT & INT_EN)
// BEHAVIOUR
// Register map (offset, access):
//   0x00 TXDATA  W
//   0x04 RXDATA  R
//   0x08 CONFIG  RW
//   0x0C TIMEOUT RW
//   0x10 STATUS  RO: {err,rx_full,rx_empty,tx_full,tx_empty}
//   0x14 INT_EN  RW [2:0]
//   0x18 INT_STAT W1C [2:0]: bit0 tx_empty rise, bit1 rx_empty fall (data arrived), bit2 i2c_error rise
// Reset values: FSM=IDLE; cfg, tmo, INT_EN, INT_STAT, irq, wait counter and edge-detect flops = 0.
//   Edge-detect flops are loaded with the live inputs on the first cycle after reset.
// FSM:
//   IDLE   -> SETUP when PSEL & !PENABLE.
//   SETUP  -> ACCESS when PSEL & PENABLE.
//   ACCESS: count 0..WAIT_STATES; PREADY=1 when count==WAIT_STATES.
//           Then -> SETUP if PSEL & !PENABLE, else IDLE.
//   PSEL low in SETUP or ACCESS -> IDLE; the transfer is aborted with no side effects.
//   PRESET high at any point -> IDLE, and any pending transfer is dropped.
// Side effects happen only in the PREADY cycle and only when PSLVERR=0. Exactly one per transfer.
// PSLVERR=1 in the PREADY cycle if any of:
//   - unmapped offset, or nonzero PADDR[ADDR_W-1:8];
//   - write to RO register, or read of TXDATA;
//   - TXDATA write with tx_full=1: no push;
//   - RXDATA read with rx_empty=1: no pop, PRDATA=0.
// Successful RXDATA read: PRDATA=rx_rdata and rx_rd_en=1 in the same cycle.
// Successful TXDATA write: tx_wr_en=1 in the PREADY cycle.
// CONFIG and TIMEOUT writes take PWDATA[CFG_W-1:0] / [TMO_W-1:0]. Reads zero-extend.
// INT_STAT:
//   - sources set on the edge detected vs. the previous cycle;
//   - write of 1 clears that bit;
//   - same-cycle set and clear -> set wins;
//   - writing 0 has no effect.
// irq updates one cycle after INT_STAT or INT_EN changes.
// Back-to-back transfers supported: SETUP may directly follow the PREADY cycle.
// STRUCTURE
// Package apb_i2c_pkg holds:
//   - offset localparams (OFS_TXDATA..OFS_INT_STAT);
//   - the state typedef enum {IDLE,SETUP,ACCESS};
//   - interrupt bit index constants.
// Sub-module apb_i2c_irq: edge detect, sticky W1C INT_STAT, INT_EN mask, registered irq.
// Top: FSM, wait counter, decode, error check, read mux.
// TESTING
// T1 WAIT_STATES=2:
//   - write 0x0000_2ABC to 0x08 -> PREADY on the 3rd ACCESS cycle;
//   - cfg=14'h2ABC the next cycle;
//   - PSLVERR=0.
// T2 tx_full=1:
//   - write 0x55 to 0x00 -> PSLVERR=1, tx_wr_en stays 0;
//   - with tx_full=0, the same write -> tx_wr_en pulses once, tx_wdata=0x55.
// T3 rx_empty=0, rx_rdata=0xCAFE, read 0x04 -> PRDATA=0xCAFE, rx_rd_en single pulse.
//    rx_empty=1, read 0x04 -> PSLVERR=1, PRDATA=0.
// T4 read 0x1C and write 0x10 -> PSLVERR=1, no register changes.
//    PSEL dropped mid-ACCESS -> FSM IDLE, no side effects.
// T5 INT_EN=0x4, pulse i2c_error -> INT_STAT[2]=1, irq=1 one cycle later.
//    Write 0x4 to 0x18 coincident with a new error rise -> bit stays 1.
//    Write 0x4 again -> irq=0.
// T6 PRESET asserted during ACCESS with WAIT_STATES=3 -> next cycle:
//   - PREADY=0, cfg=0, INT_STAT=0, irq=0;
//   - no FIFO strobes.

Source files
------------

// File: rtl/apb_i2c_pkg.sv
// Shared constants for the APB I2C register bank: register offsets,
// APB slave FSM states and interrupt source bit positions.
package apb_i2c_pkg;

  localparam logic [7:0] OFS_TXDATA   = 8'h00;
  localparam logic [7:0] OFS_RXDATA   = 8'h04;
  localparam logic [7:0] OFS_CONFIG   = 8'h08;
  localparam logic [7:0] OFS_TIMEOUT  = 8'h0C;
  localparam logic [7:0] OFS_STATUS   = 8'h10;
  localparam logic [7:0] OFS_INT_EN   = 8'h14;
  localparam logic [7:0] OFS_INT_STAT = 8'h18;

  localparam int IRQ_W        = 3;
  localparam int IRQ_TX_EMPTY = 0;
  localparam int IRQ_RX_DATA  = 1;
  localparam int IRQ_I2C_ERR  = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

endpackage

// File: rtl/apb_i2c_irq.sv
// Interrupt block: source edge detection, sticky write-1-to-clear status,
// enable mask and a registered interrupt output.
module apb_i2c_irq
  import apb_i2c_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_empty,
  input  logic             rx_empty,
  input  logic             i2c_error,
  input  logic             en_we,
  input  logic [IRQ_W-1:0] en_wdata,
  input  logic             clr_we,
  input  logic [IRQ_W-1:0] clr_mask,
  output logic [IRQ_W-1:0] int_en,
  output logic [IRQ_W-1:0] int_stat,
  output logic             irq
);

  logic [IRQ_W-1:0] src_cur;
  logic [IRQ_W-1:0] src_prev_q, src_prev_d;
  logic [IRQ_W-1:0] en_q, en_d;
  logic [IRQ_W-1:0] stat_q, stat_d;
  logic [IRQ_W-1:0] set_vec, clr_vec;
  logic             primed_q, primed_d;
  logic             irq_q, irq_d;

  // rx_empty is inverted so that "data arrived" becomes a rising edge too.
  always_comb begin
    src_cur               = '0;
    src_cur[IRQ_TX_EMPTY] = tx_empty;
    src_cur[IRQ_RX_DATA]  = ~rx_empty;
    src_cur[IRQ_I2C_ERR]  = i2c_error;
  end

  // The previous-value flops hold their reset zeros for one cycle, so edges
  // are ignored until they have captured real input levels.
  always_comb begin
    set_vec    = primed_q ? (src_cur & ~src_prev_q) : '0;
    clr_vec    = clr_we ? clr_mask : '0;
    src_prev_d = src_cur;
    primed_d   = 1'b1;
    en_d       = en_we ? en_wdata : en_q;
    stat_d     = (stat_q & ~clr_vec) | set_vec;
    irq_d      = |(stat_q & en_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_prev_q <= '0;
      primed_q   <= 1'b0;
      en_q       <= '0;
      stat_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      src_prev_q <= src_prev_d;
      primed_q   <= primed_d;
      en_q       <= en_d;
      stat_q     <= stat_d;
      irq_q      <= irq_d;
    end
  end

  assign int_en   = en_q;
  assign int_stat = stat_q;
  assign irq      = irq_q;

endmodule

// File: rtl/apb_i2c_regbank.sv
// APB3 slave register bank for the I2C core: SETUP/ACCESS FSM with
// programmable wait states, address decode, error checks and read mux.
module apb_i2c_regbank
  import apb_i2c_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int CFG_W       = 14,
  parameter int TMO_W       = 14,
  parameter int WAIT_STATES = 0
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              tx_wr_en,
  output logic [DATA_W-1:0] tx_wdata,
  input  logic              tx_full,
  input  logic              tx_empty,
  output logic              rx_rd_en,
  input  logic [DATA_W-1:0] rx_rdata,
  input  logic              rx_empty,
  input  logic              rx_full,
  input  logic              i2c_error,
  output logic [CFG_W-1:0]  cfg,
  output logic [TMO_W-1:0]  tmo,
  output logic              irq
);

  localparam logic [3:0] WS_C = WAIT_STATES[3:0];

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic [7:0]       ofs;
  logic             hi_nz, mapped, bad_dir, fifo_bad, slverr;
  logic             ready, wr_ok, rd_ok;
  logic [IRQ_W-1:0] int_en, int_stat;
  logic [DATA_W-1:0] rdata;

  assign ofs   = PADDR[7:0];
  assign hi_nz = |PADDR[ADDR_W-1:8];

  // Reset in the same cycle suppresses completion so no strobe escapes.
  assign ready = (state_q == ACCESS) && PSEL && !PRESET && (cnt_q == WS_C);
  assign wr_ok = ready && !slverr && PWRITE;
  assign rd_ok = ready && !slverr && !PWRITE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (PSEL && !PENABLE) state_d = SETUP;
      SETUP: begin
        if (!PSEL) state_d = IDLE;
        else if (PENABLE) begin
          state_d = ACCESS;
          cnt_d   = '0;
        end
      end
      ACCESS: begin
        if (!PSEL) state_d = IDLE;
        else if (cnt_q == WS_C) state_d = PENABLE ? IDLE : SETUP;
        else cnt_d = cnt_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mapped   = 1'b0;
    bad_dir  = 1'b0;
    fifo_bad = 1'b0;
    case (ofs)
      OFS_TXDATA: begin
        mapped   = 1'b1;
        bad_dir  = !PWRITE;
        fifo_bad = PWRITE && tx_full;
      end
      OFS_RXDATA: begin
        mapped   = 1'b1;
        bad_dir  = PWRITE;
        fifo_bad = !PWRITE && rx_empty;
      end
      OFS_STATUS: begin
        mapped  = 1'b1;
        bad_dir = PWRITE;
      end
      OFS_CONFIG, OFS_TIMEOUT, OFS_INT_EN, OFS_INT_STAT: mapped = 1'b1;
      default: mapped = 1'b0;
    endcase
    slverr = hi_nz || !mapped || bad_dir || fifo_bad;
  end

  always_comb begin
    rdata = '0;
    if (rd_ok) begin
      case (ofs)
        OFS_RXDATA:   rdata = rx_rdata;
        OFS_CONFIG:   rdata = DATA_W'(cfg_q);
        OFS_TIMEOUT:  rdata = DATA_W'(tmo_q);
        OFS_STATUS:   rdata = DATA_W'({i2c_error, rx_full, rx_empty, tx_full, tx_empty});
        OFS_INT_EN:   rdata = DATA_W'(int_en);
        OFS_INT_STAT: rdata = DATA_W'(int_stat);
        default:      rdata = '0;
      endcase
    end
  end

  always_comb begin
    cfg_d = cfg_q;
    tmo_d = tmo_q;
    if (wr_ok && ofs == OFS_CONFIG)  cfg_d = PWDATA[CFG_W-1:0];
    if (wr_ok && ofs == OFS_TIMEOUT) tmo_d = PWDATA[TMO_W-1:0];
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cfg_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
      tmo_q   <= tmo_d;
    end
  end

  apb_i2c_irq u_irq (
    .clk       (PCLK),
    .rst       (PRESET),
    .tx_empty  (tx_empty),
    .rx_empty  (rx_empty),
    .i2c_error (i2c_error),
    .en_we     (wr_ok && ofs == OFS_INT_EN),
    .en_wdata  (PWDATA[IRQ_W-1:0]),
    .clr_we    (wr_ok && ofs == OFS_INT_STAT),
    .clr_mask  (PWDATA[IRQ_W-1:0]),
    .int_en    (int_en),
    .int_stat  (int_stat),
    .irq       (irq)
  );

  assign PREADY   = ready;
  assign PSLVERR  = ready && slverr;
  assign PRDATA   = rdata;
  assign tx_wr_en = wr_ok && ofs == OFS_TXDATA;
  assign tx_wdata = PWDATA;
  assign rx_rd_en = rd_ok && ofs == OFS_RXDATA;
  assign cfg      = cfg_q;
  assign tmo      = tmo_q;

endmodule

// File: tb/tb_apb_i2c_regbank.sv
// Randomized self-checking bench for apb_i2c_regbank against a register-map
// level model of the bank and its interrupt sources.
module tb_apb_i2c_regbank;

  localparam int WS = 2;

  logic        PCLK = 1'b0;
  logic        PRESET, PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA, tx_wdata, rx_rdata;
  logic        PREADY, PSLVERR, tx_wr_en, rx_rd_en;
  logic        tx_full, tx_empty, rx_empty, rx_full, i2c_error;
  logic [13:0] cfg, tmo;
  logic        irq;

  always #5 PCLK = ~PCLK;

  apb_i2c_regbank #(.ADDR_W(32), .DATA_W(32), .CFG_W(14), .TMO_W(14), .WAIT_STATES(WS)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .tx_wr_en(tx_wr_en), .tx_wdata(tx_wdata), .tx_full(tx_full), .tx_empty(tx_empty),
    .rx_rd_en(rx_rd_en), .rx_rdata(rx_rdata), .rx_empty(rx_empty), .rx_full(rx_full),
    .i2c_error(i2c_error), .cfg(cfg), .tmo(tmo), .irq(irq)
  );

  int n_chk = 0, n_fail = 0;
  int tx_cnt = 0, rx_cnt = 0;
  logic [31:0] tx_last = '0;

  // Reference model state
  logic [13:0] m_cfg, m_tmo;
  logic [2:0]  m_en, m_stat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge PCLK) begin
    if (tx_wr_en === 1'b1) begin tx_cnt++; tx_last = tx_wdata; end
    if (rx_rd_en === 1'b1) rx_cnt++;
  end

  task automatic model_reset();
    m_cfg = '0; m_tmo = '0; m_en = '0; m_stat = '0;
  endtask

  // Change FIFO/core inputs while the bus is idle; sources latch on edges.
  task automatic set_in(input logic te, input logic re, input logic er,
                        input logic tf, input logic rf);
    @(posedge PCLK); #1;
    if (te && !tx_empty)  m_stat[0] = 1'b1;
    if (!re && rx_empty)  m_stat[1] = 1'b1;
    if (er && !i2c_error) m_stat[2] = 1'b1;
    tx_empty = te; rx_empty = re; i2c_error = er; tx_full = tf; rx_full = rf;
  endtask

  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic err_rise, output logic [31:0] rd, output logic se,
                      output int waits);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waits = 0;
    while (PREADY !== 1'b1 && waits < 40) begin
      @(posedge PCLK); #1;
      waits++;
    end
    rd = PRDATA; se = PSLVERR;
    if (err_rise) i2c_error = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic op(input logic wr, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] rd, exp_rd;
    logic        se, exp_se, ok;
    logic [7:0]  o;
    int          w, tx0, rx0;
    o = a[7:0];
    exp_se = (a[31:8] != 0) || !(o inside {8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18}) ||
             (wr && (o == 8'h04 || o == 8'h10)) || (!wr && o == 8'h00) ||
             (wr && o == 8'h00 && tx_full) || (!wr && o == 8'h04 && rx_empty);
    ok = !exp_se;
    exp_rd = '0;
    if (!wr && ok) begin
      case (o)
        8'h04: exp_rd = rx_rdata;
        8'h08: exp_rd = {18'b0, m_cfg};
        8'h0C: exp_rd = {18'b0, m_tmo};
        8'h10: exp_rd = {27'b0, i2c_error, rx_full, rx_empty, tx_full, tx_empty};
        8'h14: exp_rd = {29'b0, m_en};
        8'h18: exp_rd = {29'b0, m_stat};
        default: exp_rd = '0;
      endcase
    end
    tx0 = tx_cnt; rx0 = rx_cnt;
    xfer(wr, a, wd, 1'b0, rd, se, w);
    chk("ready_latency", w, WS + 1);
    chk("pslverr", se, exp_se);
    chk("prdata", rd, exp_rd);
    chk("tx_push", tx_cnt - tx0, (ok && wr && o == 8'h00) ? 1 : 0);
    chk("rx_pop", rx_cnt - rx0, (ok && !wr && o == 8'h04) ? 1 : 0);
    if (ok && wr && o == 8'h00) chk("tx_wdata", tx_last, wd);
    if (ok && wr) begin
      case (o)
        8'h08: m_cfg = wd[13:0];
        8'h0C: m_tmo = wd[13:0];
        8'h14: m_en = wd[2:0];
        8'h18: m_stat = m_stat & ~wd[2:0];
        default: ;
      endcase
    end
    chk("cfg", cfg, m_cfg);
    chk("tmo", tmo, m_tmo);
  endtask

  task automatic chk_irq();
    @(posedge PCLK); #1;
    chk("irq", irq, |(m_stat & m_en));
  endtask

  logic [31:0] alist [11] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18,
                              32'h1C, 32'h20, 32'h03, 32'h108};

  initial begin
    logic [31:0] rd, a;
    logic        se, wr;
    int          w, tx0, rx0;

    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    tx_full = 1'b0; tx_empty = 1'b1; rx_empty = 1'b1; rx_full = 1'b0; i2c_error = 1'b0;
    rx_rdata = '0;
    model_reset();
    repeat (2) @(posedge PCLK);
    #1;
    chk("rst_pready", PREADY, 0);
    chk("rst_pslverr", PSLVERR, 0);
    chk("rst_prdata", PRDATA, 0);
    chk("rst_cfg", cfg, 0);
    chk("rst_tmo", tmo, 0);
    chk("rst_irq", irq, 0);
    chk("rst_strobes", {tx_wr_en, rx_rd_en}, 0);
    PRESET = 1'b0;

    // tx_empty high through reset must not look like a rising edge
    op(1'b0, 32'h18, 0);

    // T1: CONFIG write with wait states, cfg visible next cycle
    op(1'b1, 32'h08, 32'h0000_2ABC);
    chk("t1_cfg", cfg, 14'h2ABC);

    // T2: TX full rejects, then accepts
    set_in(tx_empty, rx_empty, i2c_error, 1'b1, rx_full);
    op(1'b1, 32'h00, 32'h55);
    set_in(tx_empty, rx_empty, i2c_error, 1'b0, rx_full);
    op(1'b1, 32'h00, 32'h55);

    // T3: RX data pop, then RX empty error
    rx_rdata = 32'hCAFE;
    set_in(tx_empty, 1'b0, i2c_error, tx_full, rx_full);
    op(1'b0, 32'h04, 0);
    set_in(tx_empty, 1'b1, i2c_error, tx_full, rx_full);
    op(1'b0, 32'h04, 0);

    // T4: unmapped / read-only / high address bits / aborted transfer
    op(1'b0, 32'h1C, 0);
    op(1'b1, 32'h10, 32'hFFFF_FFFF);
    op(1'b1, 32'h108, 32'h1111);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h08; PWDATA = 32'h3FFF;
    @(posedge PCLK); #1; PENABLE = 1'b1;
    @(posedge PCLK); #1;
    chk("abort_pready", PREADY, 0);
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (4) @(posedge PCLK);
    #1;
    chk("abort_cfg", cfg, m_cfg);
    op(1'b0, 32'h08, 0);

    // T5: error interrupt, set-wins-over-clear, clear drops irq
    op(1'b1, 32'h18, 32'h7);
    op(1'b1, 32'h14, 32'h4);
    @(posedge PCLK); #1; i2c_error = 1'b1; m_stat[2] = 1'b1;
    @(posedge PCLK); #1; i2c_error = 1'b0;
    chk("t5_irq_lag", irq, 0);
    @(posedge PCLK); #1;
    chk("t5_irq_set", irq, 1);
    xfer(1'b1, 32'h18, 32'h4, 1'b1, rd, se, w);
    chk("t5_w1c_err", se, 0);
    set_in(tx_empty, rx_empty, 1'b0, tx_full, rx_full);
    op(1'b0, 32'h18, 0);
    chk_irq();
    op(1'b1, 32'h18, 32'h4);
    chk("t5_irq_hold", irq, 1);
    @(posedge PCLK); #1;
    chk("t5_irq_clr", irq, 0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      set_in(($urandom_range(0, 3) == 0) ? !tx_empty : tx_empty,
             ($urandom_range(0, 3) == 0) ? !rx_empty : rx_empty,
             ($urandom_range(0, 3) == 0) ? !i2c_error : i2c_error,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      rx_rdata = $urandom;
      a  = alist[$urandom_range(0, 10)];
      wr = 1'($urandom_range(0, 1));
      op(wr, a, $urandom);
      chk_irq();
    end

    // T6: reset during ACCESS
    op(1'b1, 32'h08, 32'h1234);
    op(1'b1, 32'h14, 32'h7);
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_irq();
    chk_irq();
    tx0 = tx_cnt; rx0 = rx_cnt;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h00; PWDATA = 32'h77;
    @(posedge PCLK); #1; PENABLE = 1'b1;
    @(posedge PCLK); #1; PRESET = 1'b1;
    @(posedge PCLK); #1;
    model_reset();
    chk("t6_pready", PREADY, 0);
    chk("t6_cfg", cfg, 0);
    chk("t6_irq", irq, 0);
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    chk("t6_tx_strobe", tx_cnt - tx0, 0);
    chk("t6_rx_strobe", rx_cnt - rx0, 0);
    op(1'b0, 32'h18, 0);
    op(1'b0, 32'h14, 0);
    op(1'b0, 32'h08, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
